// File: rtl/sys_cmd_ctrl.sv
// Command controller between the UART receiver and the register file / ALU / TX FIFO.
// It parses RX bytes into write, read and ALU commands, drives the register-file and ALU
// strobes, and pushes the response bytes into the TX FIFO. All outputs are registered.
module sys_cmd_ctrl #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned ADDR_WIDTH   = 4,
    parameter int unsigned FUN_WIDTH    = 4,
    parameter int unsigned WAIT_TIMEOUT = 255
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [DATA_WIDTH-1:0]   i_rx_p_data,
    input  logic                    i_rx_d_vld,
    input  logic                    i_frame_err,
    output logic [ADDR_WIDTH-1:0]   o_rf_addr,
    output logic [DATA_WIDTH-1:0]   o_rf_wr_data,
    output logic                    o_rf_wr_en,
    output logic                    o_rf_rd_en,
    input  logic [DATA_WIDTH-1:0]   i_rf_rd_data,
    input  logic                    i_rf_rd_vld,
    output logic [FUN_WIDTH-1:0]    o_alu_fun,
    output logic                    o_alu_en,
    output logic                    o_clk_gate_en,
    input  logic [2*DATA_WIDTH-1:0] i_alu_out,
    input  logic                    i_alu_out_vld,
    output logic [DATA_WIDTH-1:0]   o_tx_p_data,
    output logic                    o_tx_d_vld,
    input  logic                    i_tx_full
);

    localparam int unsigned CntW = $clog2(WAIT_TIMEOUT + 1);

    localparam logic [DATA_WIDTH-1:0] CmdWrite  = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CmdRead   = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CmdAluOp  = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CmdAluNop = DATA_WIDTH'(8'hDD);

    // ALU operands live at fixed register-file locations
    localparam logic [ADDR_WIDTH-1:0] OpAAddr = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] OpBAddr = ADDR_WIDTH'(1);

    typedef enum logic [3:0] {
        StIdle,
        StWrAddr,
        StWrData,
        StRdAddr,
        StRdWait,
        StOpA,
        StOpB,
        StFun,
        StAluWait,
        StTxHi,
        StTxLo
    } state_e;

    // Registered state and outputs
    state_e                  r_state;
    logic [ADDR_WIDTH-1:0]   r_rf_addr;
    logic [DATA_WIDTH-1:0]   r_rf_wr_data;
    logic                    r_rf_wr_en;
    logic                    r_rf_rd_en;
    logic [FUN_WIDTH-1:0]    r_alu_fun;
    logic                    r_alu_en;
    logic                    r_clk_gate_en;
    logic [DATA_WIDTH-1:0]   r_tx_p_data;
    logic                    r_tx_d_vld;
    logic [2*DATA_WIDTH-1:0] r_resp;
    logic [CntW-1:0]         r_wait_cnt;

    // Next-state values
    state_e                  w_state_d;
    logic [ADDR_WIDTH-1:0]   w_rf_addr_d;
    logic [DATA_WIDTH-1:0]   w_rf_wr_data_d;
    logic                    w_rf_wr_en_d;
    logic                    w_rf_rd_en_d;
    logic [FUN_WIDTH-1:0]    w_alu_fun_d;
    logic                    w_alu_en_d;
    logic                    w_clk_gate_en_d;
    logic [DATA_WIDTH-1:0]   w_tx_p_data_d;
    logic                    w_tx_d_vld_d;
    logic [2*DATA_WIDTH-1:0] w_resp_d;
    logic [CntW-1:0]         w_wait_cnt_d;

    logic [CntW-1:0]         w_wait_cnt_inc;
    logic                    w_timeout;
    logic [ADDR_WIDTH-1:0]   w_rx_addr;
    logic [FUN_WIDTH-1:0]    w_rx_fun;

    assign w_wait_cnt_inc = r_wait_cnt + CntW'(1);
    assign w_timeout      = (w_wait_cnt_inc == CntW'(WAIT_TIMEOUT));
    // Upper address / function bits are silently discarded
    assign w_rx_addr      = i_rx_p_data[ADDR_WIDTH-1:0];
    assign w_rx_fun       = i_rx_p_data[FUN_WIDTH-1:0];

    // Next-state and next-output decode; strobes default low so they last one cycle
    always_comb begin
        w_state_d       = r_state;
        w_rf_addr_d     = r_rf_addr;
        w_rf_wr_data_d  = r_rf_wr_data;
        w_rf_wr_en_d    = 1'b0;
        w_rf_rd_en_d    = 1'b0;
        w_alu_fun_d     = r_alu_fun;
        w_alu_en_d      = 1'b0;
        w_clk_gate_en_d = 1'b0;
        w_tx_p_data_d   = r_tx_p_data;
        w_tx_d_vld_d    = 1'b0;
        w_resp_d        = r_resp;
        w_wait_cnt_d    = r_wait_cnt;

        unique case (r_state)
            StIdle: begin
                if (i_rx_d_vld) begin
                    case (i_rx_p_data)
                        CmdWrite:  w_state_d = StWrAddr;
                        CmdRead:   w_state_d = StRdAddr;
                        CmdAluOp:  w_state_d = StOpA;
                        CmdAluNop: w_state_d = StFun;
                        default:   w_state_d = StIdle;
                    endcase
                end
            end

            StWrAddr: begin
                if (i_frame_err) begin
                    w_state_d = StIdle;
                end else if (i_rx_d_vld) begin
                    w_rf_addr_d = w_rx_addr;
                    w_state_d   = StWrData;
                end
            end

            StWrData: begin
                if (i_frame_err) begin
                    w_state_d = StIdle;
                end else if (i_rx_d_vld) begin
                    w_rf_wr_data_d = i_rx_p_data;
                    w_rf_wr_en_d   = 1'b1;
                    w_state_d      = StIdle;
                end
            end

            StRdAddr: begin
                if (i_frame_err) begin
                    w_state_d = StIdle;
                end else if (i_rx_d_vld) begin
                    w_rf_addr_d  = w_rx_addr;
                    w_rf_rd_en_d = 1'b1;
                    w_wait_cnt_d = '0;
                    w_state_d    = StRdWait;
                end
            end

            StRdWait: begin
                // A valid pulse on the timeout cycle still wins
                if (i_rf_rd_vld) begin
                    w_resp_d     = {{DATA_WIDTH{1'b0}}, i_rf_rd_data};
                    w_wait_cnt_d = '0;
                    w_state_d    = StTxLo;
                end else if (w_timeout) begin
                    w_wait_cnt_d = '0;
                    w_state_d    = StIdle;
                end else begin
                    w_wait_cnt_d = w_wait_cnt_inc;
                end
            end

            StOpA: begin
                if (i_frame_err) begin
                    w_state_d = StIdle;
                end else if (i_rx_d_vld) begin
                    w_rf_addr_d    = OpAAddr;
                    w_rf_wr_data_d = i_rx_p_data;
                    w_rf_wr_en_d   = 1'b1;
                    w_state_d      = StOpB;
                end
            end

            StOpB: begin
                if (i_frame_err) begin
                    w_state_d = StIdle;
                end else if (i_rx_d_vld) begin
                    w_rf_addr_d    = OpBAddr;
                    w_rf_wr_data_d = i_rx_p_data;
                    w_rf_wr_en_d   = 1'b1;
                    w_state_d      = StFun;
                end
            end

            StFun: begin
                if (i_frame_err) begin
                    w_state_d = StIdle;
                end else if (i_rx_d_vld) begin
                    w_alu_fun_d     = w_rx_fun;
                    w_alu_en_d      = 1'b1;
                    w_clk_gate_en_d = 1'b1;
                    w_wait_cnt_d    = '0;
                    w_state_d       = StAluWait;
                end
            end

            StAluWait: begin
                // Clock gate stays open until the result is captured or we give up
                if (i_alu_out_vld) begin
                    w_resp_d     = i_alu_out;
                    w_wait_cnt_d = '0;
                    w_state_d    = StTxHi;
                end else if (w_timeout) begin
                    w_wait_cnt_d = '0;
                    w_state_d    = StIdle;
                end else begin
                    w_clk_gate_en_d = 1'b1;
                    w_wait_cnt_d    = w_wait_cnt_inc;
                end
            end

            StTxHi: begin
                if (!i_tx_full) begin
                    w_tx_p_data_d = r_resp[2*DATA_WIDTH-1:DATA_WIDTH];
                    w_tx_d_vld_d  = 1'b1;
                    w_state_d     = StTxLo;
                end
            end

            StTxLo: begin
                if (!i_tx_full) begin
                    w_tx_p_data_d = r_resp[DATA_WIDTH-1:0];
                    w_tx_d_vld_d  = 1'b1;
                    w_state_d     = StIdle;
                end
            end

            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= StIdle;
            r_rf_addr     <= '0;
            r_rf_wr_data  <= '0;
            r_rf_wr_en    <= 1'b0;
            r_rf_rd_en    <= 1'b0;
            r_alu_fun     <= '0;
            r_alu_en      <= 1'b0;
            r_clk_gate_en <= 1'b0;
            r_tx_p_data   <= '0;
            r_tx_d_vld    <= 1'b0;
            r_resp        <= '0;
            r_wait_cnt    <= '0;
        end else begin
            r_state       <= w_state_d;
            r_rf_addr     <= w_rf_addr_d;
            r_rf_wr_data  <= w_rf_wr_data_d;
            r_rf_wr_en    <= w_rf_wr_en_d;
            r_rf_rd_en    <= w_rf_rd_en_d;
            r_alu_fun     <= w_alu_fun_d;
            r_alu_en      <= w_alu_en_d;
            r_clk_gate_en <= w_clk_gate_en_d;
            r_tx_p_data   <= w_tx_p_data_d;
            r_tx_d_vld    <= w_tx_d_vld_d;
            r_resp        <= w_resp_d;
            r_wait_cnt    <= w_wait_cnt_d;
        end
    end

    assign o_rf_addr     = r_rf_addr;
    assign o_rf_wr_data  = r_rf_wr_data;
    assign o_rf_wr_en    = r_rf_wr_en;
    assign o_rf_rd_en    = r_rf_rd_en;
    assign o_alu_fun     = r_alu_fun;
    assign o_alu_en      = r_alu_en;
    assign o_clk_gate_en = r_clk_gate_en;
    assign o_tx_p_data   = r_tx_p_data;
    assign o_tx_d_vld    = r_tx_d_vld;

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Directed bench for sys_cmd_ctrl: write, read, ALU, back-pressure, junk, frame error,
// timeout boundary and mid-command reset.
module tb_sys_cmd_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_p_data;
    logic        rx_d_vld;
    logic        frame_err;
    logic [3:0]  rf_addr;
    logic [7:0]  rf_wr_data;
    logic        rf_wr_en;
    logic        rf_rd_en;
    logic [7:0]  rf_rd_data;
    logic        rf_rd_vld;
    logic [3:0]  alu_fun;
    logic        alu_en;
    logic        clk_gate_en;
    logic [15:0] alu_out;
    logic        alu_out_vld;
    logic [7:0]  tx_p_data;
    logic        tx_d_vld;
    logic        tx_full;

    int n_checks = 0;
    int n_pass   = 0;
    int wr_cnt   = 0;
    int rd_cnt   = 0;
    int alu_cnt  = 0;
    logic [7:0] tx_q[$];

    always #5 clk = ~clk;

    sys_cmd_ctrl #(
        .DATA_WIDTH   (8),
        .ADDR_WIDTH   (4),
        .FUN_WIDTH    (4),
        .WAIT_TIMEOUT (255)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_rx_p_data   (rx_p_data),
        .i_rx_d_vld    (rx_d_vld),
        .i_frame_err   (frame_err),
        .o_rf_addr     (rf_addr),
        .o_rf_wr_data  (rf_wr_data),
        .o_rf_wr_en    (rf_wr_en),
        .o_rf_rd_en    (rf_rd_en),
        .i_rf_rd_data  (rf_rd_data),
        .i_rf_rd_vld   (rf_rd_vld),
        .o_alu_fun     (alu_fun),
        .o_alu_en      (alu_en),
        .o_clk_gate_en (clk_gate_en),
        .i_alu_out     (alu_out),
        .i_alu_out_vld (alu_out_vld),
        .o_tx_p_data   (tx_p_data),
        .o_tx_d_vld    (tx_d_vld),
        .i_tx_full     (tx_full)
    );

    // Strobe and TX monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (tx_d_vld) tx_q.push_back(tx_p_data);
        if (rf_wr_en) wr_cnt++;
        if (rf_rd_en) rd_cnt++;
        if (alu_en)   alu_cnt++;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_p_data = b;
        rx_d_vld  = 1'b1;
        step();
        rx_d_vld  = 1'b0;
    endtask

    task automatic clear_mon();
        wr_cnt  = 0;
        rd_cnt  = 0;
        alu_cnt = 0;
        tx_q.delete();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".rf_addr"},     16'(rf_addr),     16'h0);
        chk({tag, ".rf_wr_data"},  16'(rf_wr_data),  16'h0);
        chk({tag, ".rf_wr_en"},    16'(rf_wr_en),    16'h0);
        chk({tag, ".rf_rd_en"},    16'(rf_rd_en),    16'h0);
        chk({tag, ".alu_fun"},     16'(alu_fun),     16'h0);
        chk({tag, ".alu_en"},      16'(alu_en),      16'h0);
        chk({tag, ".clk_gate_en"}, 16'(clk_gate_en), 16'h0);
        chk({tag, ".tx_p_data"},   16'(tx_p_data),   16'h0);
        chk({tag, ".tx_d_vld"},    16'(tx_d_vld),    16'h0);
    endtask

    initial begin
        rst         = 1'b1;
        rx_p_data   = 8'h00;
        rx_d_vld    = 1'b0;
        frame_err   = 1'b0;
        rf_rd_data  = 8'h00;
        rf_rd_vld   = 1'b0;
        alu_out     = 16'h0000;
        alu_out_vld = 1'b0;
        tx_full     = 1'b0;
        idle(3);
        chk_all_zero("reset");
        rst = 1'b0;
        idle(2);

        // Register write AA,05,A6
        clear_mon();
        send_byte(8'hAA);
        chk("wr.cmd_no_strobe", 16'(rf_wr_en), 16'h0);
        send_byte(8'h05);
        chk("wr.addr_latched", 16'(rf_addr), 16'h5);
        chk("wr.addr_no_strobe", 16'(rf_wr_en), 16'h0);
        send_byte(8'hA6);
        chk("wr.wr_en", 16'(rf_wr_en), 16'h1);
        chk("wr.addr", 16'(rf_addr), 16'h5);
        chk("wr.data", 16'(rf_wr_data), 16'hA6);
        step();
        chk("wr.wr_en_one_cycle", 16'(rf_wr_en), 16'h0);
        idle(3);
        chk("wr.pulse_count", 16'(wr_cnt), 16'd1);
        chk("wr.no_tx", 16'(tx_q.size()), 16'd0);

        // Register read BB,05 then RF_RD_VLD with A6
        clear_mon();
        send_byte(8'hBB);
        send_byte(8'h05);
        chk("rd.rd_en", 16'(rf_rd_en), 16'h1);
        chk("rd.addr", 16'(rf_addr), 16'h5);
        idle(3);
        rf_rd_data = 8'hA6;
        rf_rd_vld  = 1'b1;
        step();
        rf_rd_vld  = 1'b0;
        idle(4);
        chk("rd.rd_count", 16'(rd_cnt), 16'd1);
        chk("rd.tx_count", 16'(tx_q.size()), 16'd1);
        chk("rd.tx_byte", 16'(tx_q[0]), 16'hA6);

        // ALU with operands CC,28,1E,01; result 000A
        clear_mon();
        send_byte(8'hCC);
        send_byte(8'h28);
        chk("aluop.opa_wr_en", 16'(rf_wr_en), 16'h1);
        chk("aluop.opa_addr", 16'(rf_addr), 16'h0);
        chk("aluop.opa_data", 16'(rf_wr_data), 16'h28);
        send_byte(8'h1E);
        chk("aluop.opb_wr_en", 16'(rf_wr_en), 16'h1);
        chk("aluop.opb_addr", 16'(rf_addr), 16'h1);
        chk("aluop.opb_data", 16'(rf_wr_data), 16'h1E);
        send_byte(8'h01);
        chk("aluop.alu_en", 16'(alu_en), 16'h1);
        chk("aluop.alu_fun", 16'(alu_fun), 16'h1);
        chk("aluop.gate_with_en", 16'(clk_gate_en), 16'h1);
        idle(4);
        chk("aluop.alu_en_one_cycle", 16'(alu_en), 16'h0);
        chk("aluop.gate_held", 16'(clk_gate_en), 16'h1);
        alu_out     = 16'h000A;
        alu_out_vld = 1'b1;
        step();
        alu_out_vld = 1'b0;
        chk("aluop.gate_dropped", 16'(clk_gate_en), 16'h0);
        idle(4);
        chk("aluop.wr_count", 16'(wr_cnt), 16'd2);
        chk("aluop.alu_count", 16'(alu_cnt), 16'd1);
        chk("aluop.tx_count", 16'(tx_q.size()), 16'd2);
        chk("aluop.tx_hi", 16'(tx_q[0]), 16'h00);
        chk("aluop.tx_lo", 16'(tx_q[1]), 16'h0A);

        // ALU without operands under TX back-pressure
        clear_mon();
        tx_full = 1'b1;
        send_byte(8'hDD);
        send_byte(8'h00);
        chk("alunop.alu_en", 16'(alu_en), 16'h1);
        chk("alunop.alu_fun", 16'(alu_fun), 16'h0);
        alu_out     = 16'h0046;
        alu_out_vld = 1'b1;
        step();
        alu_out_vld = 1'b0;
        idle(20);
        chk("alunop.no_push_while_full", 16'(tx_q.size()), 16'd0);
        chk("alunop.wr_count", 16'(wr_cnt), 16'd0);
        tx_full = 1'b0;
        idle(5);
        chk("alunop.tx_count", 16'(tx_q.size()), 16'd2);
        chk("alunop.tx_hi", 16'(tx_q[0]), 16'h00);
        chk("alunop.tx_lo", 16'(tx_q[1]), 16'h46);

        // Junk byte in IDLE is ignored
        clear_mon();
        send_byte(8'h55);
        send_byte(8'h05);
        send_byte(8'hA6);
        idle(2);
        chk("junk.no_strobes", 16'(wr_cnt + rd_cnt + alu_cnt), 16'd0);

        // Frame error in WR_DATA coinciding with a byte; the byte is lost
        clear_mon();
        send_byte(8'hAA);
        send_byte(8'h03);
        frame_err = 1'b1;
        send_byte(8'h99);
        frame_err = 1'b0;
        chk("ferr.no_wr_en", 16'(rf_wr_en), 16'h0);
        send_byte(8'h7F);
        idle(2);
        chk("ferr.back_in_idle", 16'(wr_cnt), 16'd0);
        send_byte(8'hAA);
        send_byte(8'h03);
        send_byte(8'h7F);
        chk("ferr.clean_wr_en", 16'(rf_wr_en), 16'h1);
        chk("ferr.clean_addr", 16'(rf_addr), 16'h3);
        chk("ferr.clean_data", 16'(rf_wr_data), 16'h7F);
        idle(2);
        chk("ferr.clean_count", 16'(wr_cnt), 16'd1);

        // Frame error in FUN suppresses ALU start
        clear_mon();
        send_byte(8'hDD);
        frame_err = 1'b1;
        send_byte(8'h02);
        frame_err = 1'b0;
        chk("ferrfun.gate", 16'(clk_gate_en), 16'h0);
        idle(2);
        chk("ferrfun.alu_count", 16'(alu_cnt), 16'd0);

        // Read with valid on the last wait cycle is accepted; RX bytes in RD_WAIT dropped
        clear_mon();
        send_byte(8'hBB);
        send_byte(8'h12);
        chk("tmo_edge.addr_upper_ignored", 16'(rf_addr), 16'h2);
        send_byte(8'hAA);
        send_byte(8'h05);
        send_byte(8'hA6);
        idle(251);
        rf_rd_data = 8'h5A;
        rf_rd_vld  = 1'b1;
        step();
        rf_rd_vld  = 1'b0;
        idle(4);
        chk("tmo_edge.rx_dropped", 16'(wr_cnt), 16'd0);
        chk("tmo_edge.tx_count", 16'(tx_q.size()), 16'd1);
        chk("tmo_edge.tx_byte", 16'(tx_q[0]), 16'h5A);

        // Read with no valid times out; a late valid is not answered
        clear_mon();
        send_byte(8'hBB);
        send_byte(8'h02);
        idle(255);
        rf_rd_data = 8'hC3;
        rf_rd_vld  = 1'b1;
        step();
        rf_rd_vld  = 1'b0;
        idle(5);
        chk("tmo.rd_count", 16'(rd_cnt), 16'd1);
        chk("tmo.no_tx", 16'(tx_q.size()), 16'd0);
        send_byte(8'hAA);
        send_byte(8'h09);
        send_byte(8'h11);
        chk("tmo.next_cmd_wr_en", 16'(rf_wr_en), 16'h1);
        chk("tmo.next_cmd_addr", 16'(rf_addr), 16'h9);

        // Reset while waiting on the ALU
        clear_mon();
        send_byte(8'hDD);
        send_byte(8'h03);
        idle(2);
        chk("rstmid.gate_before", 16'(clk_gate_en), 16'h1);
        rst = 1'b1;
        step();
        chk_all_zero("rstmid");
        rst = 1'b0;
        step();
        chk("rstmid.no_strobe_after", 16'({rf_wr_en, rf_rd_en, alu_en, tx_d_vld}), 16'h0);
        alu_out     = 16'h1234;
        alu_out_vld = 1'b1;
        step();
        alu_out_vld = 1'b0;
        idle(5);
        chk("rstmid.no_tx", 16'(tx_q.size()), 16'd0);
        chk("rstmid.gate_stays_low", 16'(clk_gate_en), 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sys_cmd_ctrl.md
Name: sys_cmd_ctrl

Overview:
- Command controller sitting directly downstream of the UART receiver and upstream of the register file, ALU and TX FIFO.
- Parses received byte streams into commands:
  - 0xAA: register write
  - 0xBB: register read
  - 0xCC: ALU with operands
  - 0xDD: ALU without operands
- Drives register file and ALU strobes, then pushes response bytes into the TX FIFO for transmission.
- Single clock domain; all inputs are already synchronised to CLK.

Parameters:
- DATA_WIDTH, 8, width of received/transmitted bytes and register data.
- ADDR_WIDTH, 4, register file address width; only the low ADDR_WIDTH bits of an address byte are used.
- FUN_WIDTH, 4, ALU function width; only the low FUN_WIDTH bits of a function byte are used.
- WAIT_TIMEOUT, 255, maximum cycles to wait for RF_RD_VLD or ALU_OUT_VLD before abandoning a command.

Ports:
- CLK  in  1  system clock
- RST  in  1  reset; active-high, synchronous to CLK
- RX_P_DATA  in  DATA_WIDTH  received byte
- RX_D_VLD  in  1  one-cycle pulse; RX_P_DATA valid
- FRAME_ERR  in  1  one-cycle pulse; parity or stop error on the current RX frame
- RF_ADDR  out  ADDR_WIDTH  register file address
- RF_WR_DATA  out  DATA_WIDTH  register file write data
- RF_WR_EN  out  1  one-cycle write strobe
- RF_RD_EN  out  1  one-cycle read strobe
- RF_RD_DATA  in  DATA_WIDTH  read data
- RF_RD_VLD  in  1  read data valid pulse
- ALU_FUN  out  FUN_WIDTH  ALU function
- ALU_EN  out  1  one-cycle ALU start strobe
- CLK_GATE_EN  out  1  ALU clock-gate enable
- ALU_OUT  in  2*DATA_WIDTH  ALU result
- ALU_OUT_VLD  in  1  result valid pulse
- TX_P_DATA  out  DATA_WIDTH  byte to TX FIFO
- TX_D_VLD  out  1  one-cycle FIFO push
- TX_FULL  in  1  TX FIFO full

Behaviour:
- Reset (RST=1 at a CLK edge):
  - State goes to IDLE.
  - All strobes (RF_WR_EN, RF_RD_EN, ALU_EN, TX_D_VLD) and CLK_GATE_EN are 0.
  - RF_ADDR, RF_WR_DATA, ALU_FUN and TX_P_DATA are 0.
  - The wait counter is cleared.
  - Reset mid-command discards all partial state; no strobe is issued in the cycle after reset.
- All outputs are registered.
  - A strobe caused by a byte's RX_D_VLD is high in the cycle after that pulse, for exactly one cycle.
- States:
  - IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OPA, OPB, FUN, ALU_WAIT, TX_HI, TX_LO.
- IDLE, on RX_D_VLD:
  - 0xAA goes to WR_ADDR.
  - 0xBB goes to RD_ADDR.
  - 0xCC goes to OPA.
  - 0xDD goes to FUN.
  - Any other byte is ignored; stay in IDLE.
- WR_ADDR: the byte is latched into RF_ADDR; go to WR_DATA.
- WR_DATA: the byte is placed on RF_WR_DATA and RF_WR_EN pulses; go to IDLE.
- RD_ADDR: the byte is placed on RF_ADDR and RF_RD_EN pulses; go to RD_WAIT.
- RD_WAIT:
  - On RF_RD_VLD, capture RF_RD_DATA into the low response byte; go to TX_LO (single-byte response).
- OPA: write the byte to address 0 (RF_WR_EN pulse); go to OPB.
- OPB: write the byte to address 1 (RF_WR_EN pulse); go to FUN.
- FUN:
  - Latch the low FUN_WIDTH bits into ALU_FUN and pulse ALU_EN.
  - Set CLK_GATE_EN to 1 in the same cycle as ALU_EN.
  - Go to ALU_WAIT.
- ALU_WAIT:
  - CLK_GATE_EN stays 1.
  - On ALU_OUT_VLD, capture ALU_OUT and drop CLK_GATE_EN in the next cycle.
  - Go to TX_HI.
- TX_HI / TX_LO:
  - Push the response byte when TX_FULL=0: TX_D_VLD=1 for one cycle with the byte on TX_P_DATA.
  - While TX_FULL=1, hold the state with TX_D_VLD=0 indefinitely.
  - ALU result is sent high byte first, then low byte.
  - After TX_LO is pushed, go to IDLE.
- RX_D_VLD arriving in RD_WAIT, ALU_WAIT, TX_HI or TX_LO: the byte is dropped and the state is unaffected.
- FRAME_ERR in any byte-collecting state (WR_ADDR, WR_DATA, RD_ADDR, OPA, OPB, FUN):
  - Return to IDLE; no strobe is issued.
  - If FRAME_ERR and RX_D_VLD coincide, FRAME_ERR wins and the byte is discarded.
  - FRAME_ERR in IDLE or later states is ignored.
- Timeout:
  - The wait counter counts cycles in RD_WAIT/ALU_WAIT.
  - Reaching WAIT_TIMEOUT returns to IDLE with no TX push and CLK_GATE_EN=0.
  - A valid pulse arriving on the same cycle as the timeout is accepted.
- Address byte upper bits beyond ADDR_WIDTH are ignored; no wrap error is reported.

Test Plan:
- RX bytes AA,05,A6 → exactly one RF_WR_EN pulse with RF_ADDR=5, RF_WR_DATA=A6; no TX push.
- RX bytes BB,05, then RF_RD_VLD with RF_RD_DATA=A6 → RF_RD_EN with RF_ADDR=5, then one TX push of A6.
- RX bytes CC,28,1E,01; ALU_OUT=000A → writes addr0=28 and addr1=1E, ALU_EN with ALU_FUN=1, CLK_GATE_EN high until capture, then TX pushes 00 then 0A.
- RX bytes DD,00; ALU_OUT=0046 with TX_FULL=1 held 20 cycles → no push while full; then 00,46 pushed in order, none lost or duplicated.
- Error/junk handling:
  - RX byte 55 → ignored, stay in IDLE.
  - RX bytes AA,03 followed by FRAME_ERR → IDLE, no RF_WR_EN.
  - A following AA,03,7F command → a clean write of 7F to addr 3.
- Abort cases:
  - RX bytes BB,02 with no RF_RD_VLD → IDLE after 255 cycles, no TX push.
  - RST asserted in ALU_WAIT → all outputs 0 next cycle.
